cpu_phase_ctrl: RTL and testbench

//  Sequencer for the 4-phase multi-cycle CPU core: issues one-hot FT/DC/EX/WB phase

---
 rtl/cpu_phase_pkg.sv | 44 ++++
 rtl/cpu_phase_if.sv | 39 +++
 rtl/cpu_phase_ctrl_stall_timer.sv | 33 +++
 rtl/cpu_phase_ctrl.sv | 102 ++++++++++
 tb/tb_cpu_phase_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_phase_pkg.sv
// Shared definitions for the CPU phase sequencer: state encodings, phase-enable
// bundle and the stall-timer width helper. CPU_PHASE_SINGLE_STEP_EN uses ST_PAUSE.
package cpu_phase_pkg;

  localparam int STATE_W = 3;

  // The encoding is fixed so that debug and trace logic can decode the raw state.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FT    = 3'd1,
    ST_DC    = 3'd2,
    ST_EX    = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERR   = 3'd6,
    ST_PAUSE = 3'd7
  } state_t;

  typedef struct packed {
    logic ft;
    logic dc;
    logic ex;
    logic wb;
  } phase_en_t;

  function automatic phase_en_t phase_decode(state_t s);
    phase_en_t en;
    en.ft = (s == ST_FT);
    en.dc = (s == ST_DC);
    en.ex = (s == ST_EX);
    en.wb = (s == ST_WB);
    return en;
  endfunction

  function automatic bit is_running(state_t s);
    return (s == ST_FT) || (s == ST_DC) || (s == ST_EX) || (s == ST_WB);
  endfunction

  // The counter must be able to hold the limit value itself.
  function automatic int unsigned timer_width(int unsigned limit);
    return (limit > 1) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/cpu_phase_if.sv
// Control/status bundle between the CPU top level and the phase sequencer.
// CPU_PHASE_SINGLE_STEP_EN adds the step_mode/step controls.
interface cpu_phase_if #(
  parameter int CNT_W = 16
) ();

  logic             start;
  logic             stall;
  logic             halt_req;
`ifdef CPU_PHASE_SINGLE_STEP_EN
  logic             step_mode;
  logic             step;
`endif
  logic             en_ft;
  logic             en_dc;
  logic             en_ex;
  logic             en_wb;
  logic             running;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, stall, halt_req,
`ifdef CPU_PHASE_SINGLE_STEP_EN
    output step_mode, step,
`endif
    input  en_ft, en_dc, en_ex, en_wb, running, halted, fault, retired
  );

  modport slave (
    input  start, stall, halt_req,
`ifdef CPU_PHASE_SINGLE_STEP_EN
    input  step_mode, step,
`endif
    output en_ft, en_dc, en_ex, en_wb, running, halted, fault, retired
  );

endinterface

// File: rtl/cpu_phase_ctrl_stall_timer.sv
// Counts consecutive stalled EX cycles; expired is high once the count equals LIMIT.
// LIMIT = 0 disables expiry entirely.
module stall_timer
  import cpu_phase_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned W = timer_width(LIMIT);

  logic [W-1:0] cnt;

  // NOTE: sequential state is always written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (LIMIT != 0) && (cnt == W'(LIMIT));

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Four-phase sequencer for the multi-cycle CPU: one-hot FT/DC/EX/WB enables,
// start/halt control, EX stall with timeout fault and retired-instruction counter.
// Optional single-step mode is built when CPU_PHASE_SINGLE_STEP_EN is defined.
module cpu_phase_ctrl
  import cpu_phase_pkg::*;
#(
  parameter int          CNT_W         = 16,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst_n,
  cpu_phase_if.slave bus
);

  state_t           state;
  state_t           state_d;
  logic             halt_latch;
  logic             stall_expired;
  logic [CNT_W-1:0] retired;
  phase_en_t        en;

  stall_timer #(
    .LIMIT (STALL_TIMEOUT)
  ) u_stall_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != ST_EX),
    .count   ((state == ST_EX) && bus.stall),
    .expired (stall_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE,
      ST_HALT:  if (bus.start) state_d = ST_FT;
      ST_FT:    state_d = ST_DC;
      ST_DC:    state_d = ST_EX;
      ST_EX: begin
        // A stall released in the expiry cycle still completes normally.
        if (!bus.stall)         state_d = ST_WB;
        else if (stall_expired) state_d = ST_ERR;
      end
      ST_WB: begin
        if (halt_latch) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FT;
`ifdef CPU_PHASE_SINGLE_STEP_EN
          if (bus.step_mode) state_d = ST_PAUSE;
`endif
        end
      end
      ST_ERR:   state_d = ST_ERR;
`ifdef CPU_PHASE_SINGLE_STEP_EN
      ST_PAUSE: if (bus.step || !bus.step_mode) state_d = ST_FT;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Halt requests are only meaningful while decode/execute own the instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_latch <= 1'b0;
    end else if (state_d == ST_FT) begin
      halt_latch <= 1'b0;
    end else if (bus.halt_req && ((state == ST_DC) || (state == ST_EX))) begin
      halt_latch <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (state == ST_WB) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Outputs are pure decodes of the state flop, so they change only on clk.
  assign en          = phase_decode(state);
  assign bus.en_ft   = en.ft;
  assign bus.en_dc   = en.dc;
  assign bus.en_ex   = en.ex;
  assign bus.en_wb   = en.wb;
  assign bus.running = is_running(state);
  assign bus.halted  = (state == ST_HALT);
  assign bus.fault   = (state == ST_ERR);
  assign bus.retired = retired;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Directed bench for cpu_phase_ctrl: one instance with default parameters and one
// with a short stall timeout and 4-bit counter for expiry and wrap cases.
module tb_cpu_phase_ctrl;

  localparam logic [31:0] P_IDL = 32'b0000_000;
  localparam logic [31:0] P_FT  = 32'b1000_100;
  localparam logic [31:0] P_DC  = 32'b0100_100;
  localparam logic [31:0] P_EX  = 32'b0010_100;
  localparam logic [31:0] P_WB  = 32'b0001_100;
  localparam logic [31:0] P_HLT = 32'b0000_010;
  localparam logic [31:0] P_ERR = 32'b0000_001;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu_phase_if #(.CNT_W(16)) bus_a ();
  cpu_phase_if #(.CNT_W(4))  bus_b ();

  cpu_phase_ctrl #(.CNT_W(16), .STALL_TIMEOUT(255)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a.slave)
  );

  cpu_phase_ctrl #(.CNT_W(4), .STALL_TIMEOUT(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b.slave)
  );

  function automatic logic [31:0] ph_a();
    return {25'd0, bus_a.en_ft, bus_a.en_dc, bus_a.en_ex, bus_a.en_wb,
            bus_a.running, bus_a.halted, bus_a.fault};
  endfunction

  function automatic logic [31:0] ph_b();
    return {25'd0, bus_b.en_ft, bus_b.en_dc, bus_b.en_ex, bus_b.en_wb,
            bus_b.running, bus_b.halted, bus_b.fault};
  endfunction

  function automatic logic [31:0] ret_a();
    return 32'(bus_a.retired);
  endfunction

  function automatic logic [31:0] ret_b();
    return 32'(bus_b.retired);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.start = 1'b0; bus_a.stall = 1'b0; bus_a.halt_req = 1'b0;
    bus_b.start = 1'b0; bus_b.stall = 1'b0; bus_b.halt_req = 1'b0;
`ifdef CPU_PHASE_SINGLE_STEP_EN
    bus_a.step_mode = 1'b0; bus_a.step = 1'b0;
    bus_b.step_mode = 1'b0; bus_b.step = 1'b0;
`endif
    tick(); tick();
    check("a_reset_phase", ph_a(), P_IDL);
    check("a_reset_ret", ret_a(), 32'd0);
    check("b_reset_phase", ph_b(), P_IDL);
    check("b_reset_ret", ret_b(), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    tick();
    check("a_idle_hold", ph_a(), P_IDL);

    // Free-running loop, START pulsed once; a START during DC must be ignored.
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("loop_ft", ph_a(), P_FT); tick();
      check("loop_dc", ph_a(), P_DC);
      if (i == 1) bus_a.start = 1'b1;
      tick(); bus_a.start = 1'b0;
      check("loop_ex", ph_a(), P_EX); tick();
      check("loop_wb", ph_a(), P_WB); tick();
    end
    check("loop_ret3", ret_a(), 32'd3);
    check("loop_ft_again", ph_a(), P_FT);

    // Five stalled EX cycles: EX lasts six cycles, then WB without fault.
    tick();
    check("stall_dc", ph_a(), P_DC);
    bus_a.stall = 1'b1; tick();
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) bus_a.stall = 1'b0;
      check("stall_ex_hold", ph_a(), P_EX);
      tick();
    end
    check("stall_wb", ph_a(), P_WB);
    tick();
    check("stall_ret4", ret_a(), 32'd4);
    check("stall_ft", ph_a(), P_FT);

    // Halt: HALT_REQ in FT and WB ignored, in DC of instr 2 honoured.
    rst_n_a = 1'b0; tick(); rst_n_a = 1'b1;
    check("halt_pre_reset", ph_a(), P_IDL);
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    bus_a.halt_req = 1'b1;
    check("halt_i1_ft", ph_a(), P_FT); tick();
    bus_a.halt_req = 1'b0;
    check("halt_i1_dc", ph_a(), P_DC); tick();
    check("halt_i1_ex", ph_a(), P_EX); tick();
    check("halt_i1_wb", ph_a(), P_WB);
    bus_a.halt_req = 1'b1; tick(); bus_a.halt_req = 1'b0;
    check("halt_ft_ignored", ph_a(), P_FT);
    check("halt_ret1", ret_a(), 32'd1);
    tick();
    check("halt_i2_dc", ph_a(), P_DC);
    bus_a.halt_req = 1'b1; tick(); bus_a.halt_req = 1'b0;
    check("halt_i2_ex", ph_a(), P_EX); tick();
    check("halt_i2_wb", ph_a(), P_WB); tick();
    check("halt_state", ph_a(), P_HLT);
    check("halt_ret2", ret_a(), 32'd2);
    tick();
    check("halt_hold", ph_a(), P_HLT);
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    check("halt_resume_ft", ph_a(), P_FT);
    repeat (3) tick();
    check("halt_i3_wb", ph_a(), P_WB); tick();
    check("halt_latch_cleared", ph_a(), P_FT);
    check("halt_ret3", ret_a(), 32'd3);

    // Timeout 4: stall released in the fifth EX cycle still reaches WB.
    bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
    check("b_ft", ph_b(), P_FT); tick();
    check("b_dc", ph_b(), P_DC);
    bus_b.stall = 1'b1; tick();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) bus_b.stall = 1'b0;
      check("b_ex_boundary", ph_b(), P_EX);
      tick();
    end
    check("b_wb_no_fault", ph_b(), P_WB); tick();
    check("b_ret1", ret_b(), 32'd1);

    // 4-bit counter wraps 15 -> 0.
    for (int i = 0; i < 14; i++) repeat (4) tick();
    check("b_ret15", ret_b(), 32'd15);
    check("b_ft_before_wrap", ph_b(), P_FT);
    repeat (4) tick();
    check("b_wrap", ret_b(), 32'd0);

    // Stall held: EX lasts five cycles, then sticky fault; START ignored.
    tick();
    bus_b.stall = 1'b1; tick();
    for (int k = 1; k <= 5; k++) begin
      check("b_ex_timeout", ph_b(), P_EX);
      tick();
    end
    check("b_err", ph_b(), P_ERR);
    bus_b.start = 1'b1; tick();
    check("b_err_start1", ph_b(), P_ERR); tick();
    check("b_err_start2", ph_b(), P_ERR);
    bus_b.start = 1'b0; bus_b.stall = 1'b0;
    rst_n_b = 1'b0; tick(); rst_n_b = 1'b1;
    check("b_err_reset", ph_b(), P_IDL);
    check("b_err_reset_ret", ret_b(), 32'd0);

    // Reset in a stalled EX aborts the phase; the next stall starts from zero.
    bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
    tick(); bus_b.stall = 1'b1; tick(); tick(); tick();
    check("b_mid_ex", ph_b(), P_EX);
    rst_n_b = 1'b0; tick(); rst_n_b = 1'b1;
    check("b_mid_reset", ph_b(), P_IDL);
    check("b_mid_reset_ret", ret_b(), 32'd0);
    bus_b.stall = 1'b0;
    bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
    tick(); bus_b.stall = 1'b1; tick();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) bus_b.stall = 1'b0;
      check("b_timer_fresh", ph_b(), P_EX);
      tick();
    end
    check("b_timer_fresh_wb", ph_b(), P_WB);

`ifdef CPU_PHASE_SINGLE_STEP_EN
    // Single step: each STEP pulse runs one instruction; STEP while running ignored.
    rst_n_a = 1'b0; tick(); rst_n_a = 1'b1;
    bus_a.step_mode = 1'b1;
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    check("step_ft", ph_a(), P_FT); tick();
    check("step_dc", ph_a(), P_DC);
    bus_a.step = 1'b1; tick(); bus_a.step = 1'b0;
    check("step_ex", ph_a(), P_EX); tick();
    check("step_wb", ph_a(), P_WB); tick();
    check("step_pause", ph_a(), P_IDL);
    check("step_ret1", ret_a(), 32'd1);
    tick();
    check("step_pause_hold", ph_a(), P_IDL);
    bus_a.step = 1'b1; tick(); bus_a.step = 1'b0;
    check("step_go_ft", ph_a(), P_FT);
    repeat (3) tick();
    check("step_wb2", ph_a(), P_WB); tick();
    check("step_pause2", ph_a(), P_IDL);
    check("step_ret2", ret_a(), 32'd2);
    bus_a.step_mode = 1'b0; tick();
    check("step_mode_off_ft", ph_a(), P_FT);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
